// File: rtl/uart_rx_if.sv
// Handshake bundle between the UART receive engine and its consumer.
// The engine drives the received word and its status; the consumer drives rx_ready.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 framing_error;
  logic                 parity_error;
  logic                 overrun_error;
  logic                 busy;

  modport master (
    input  rx_ready,
    output rx_data, rx_valid, framing_error, parity_error, overrun_error, busy
  );

  modport slave (
    output rx_ready,
    input  rx_data, rx_valid, framing_error, parity_error, overrun_error, busy
  );
endinterface

// File: rtl/uart_rx_engine.sv
// UART receive engine: start detect, mid-bit sampling, parity/stop checking and a
// one-word output buffer with a valid/ready handshake and overrun reporting.
module uart_rx_engine #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic      clk,
  input  logic      n_rst,
  input  logic      serial_in,
  uart_rx_if.master rx
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF_TC   = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] FULL_TC   = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD       = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    LOAD
  } state_t;

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 prev_line;
  logic                 ferr;
  logic                 perr;
  logic                 tick;

  // The start state waits half a bit so every later sample lands mid-bit.
  always_comb begin
    tick = (state == START) ? (tick_cnt == HALF_TC) : (tick_cnt == FULL_TC);
  end

  assign rx.busy = (state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state            <= IDLE;
      tick_cnt         <= '0;
      bit_cnt          <= '0;
      shift            <= '0;
      prev_line        <= 1'b1;
      ferr             <= 1'b0;
      perr             <= 1'b0;
      rx.rx_data       <= '0;
      rx.rx_valid      <= 1'b0;
      rx.framing_error <= 1'b0;
      rx.parity_error  <= 1'b0;
      rx.overrun_error <= 1'b0;
    end else begin
      prev_line        <= serial_in;
      rx.framing_error <= 1'b0;
      rx.parity_error  <= 1'b0;
      rx.overrun_error <= 1'b0;

      // NOTE: non-blocking assignments make the later LOAD write to rx_valid win
      // over this handshake clear when both happen on the same edge.
      if (rx.rx_valid && rx.rx_ready) rx.rx_valid <= 1'b0;

      if (state != IDLE && state != LOAD) begin
        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      end

      case (state)
        IDLE: begin
          if (!serial_in && prev_line) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end

        START: begin
          if (tick) begin
            if (serial_in) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
              ferr    <= 1'b0;
              perr    <= 1'b0;
            end
          end
        end

        DATA: begin
          if (tick) begin
            shift <= {serial_in, shift[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end

        PARITY: begin
          if (tick) begin
            perr  <= ((^shift) ^ serial_in) != ODD;
            state <= STOP;
          end
        end

        STOP: begin
          if (tick) begin
            if (!serial_in) ferr <= 1'b1;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= LOAD;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end

        LOAD: begin
          state            <= IDLE;
          rx.framing_error <= ferr;
          rx.parity_error  <= perr;
          if (!ferr && !perr) begin
            if (!rx.rx_valid || rx.rx_ready) begin
              rx.rx_data  <= shift;
              rx.rx_valid <= 1'b1;
            end else begin
              rx.overrun_error <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: directed frames plus randomized frames
// checked against a frame-level model of the output buffer and error pulses.
module tb_uart_rx_engine;

  localparam int CLKS = 16;
  localparam int LAT8 = CLKS / 2 + (8 + 1 + 1) * CLKS + 3;  // falling edge to rx_valid

  logic clk = 1'b0;
  logic n_rst;
  logic serial_in;
  logic serial_in2;
  logic rx_ready;

  uart_rx_if #(.DATA_BITS(8)) rx  ();
  uart_rx_if #(.DATA_BITS(7)) rx2 ();

  assign rx.rx_ready  = rx_ready;
  assign rx2.rx_ready = 1'b0;

  uart_rx_engine #(
    .CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .rx(rx)
  );

  uart_rx_engine #(
    .CLKS_PER_BIT(CLKS), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)
  ) dut2 (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in2), .rx(rx2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Free-running monitors; the stimulus reads differences between snapshots.
  int cyc = 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, busy_cnt = 0, e2_cnt = 0;
  int rise_cyc = -1;
  logic valid_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx.framing_error) fe_cnt <= fe_cnt + 1;
    if (rx.parity_error)  pe_cnt <= pe_cnt + 1;
    if (rx.overrun_error) ov_cnt <= ov_cnt + 1;
    if (rx.busy)          busy_cnt <= busy_cnt + 1;
    if (rx2.framing_error || rx2.parity_error || rx2.overrun_error) e2_cnt <= e2_cnt + 1;
    if (rx.rx_valid && !valid_q) rise_cyc <= cyc;
    valid_q <= rx.rx_valid;
  end

  int fe_b, pe_b, ov_b, busy_b, e2_b, fall_cyc;

  // Reference model of the consumer-visible buffer.
  logic       m_valid;
  logic [7:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    fe_b = fe_cnt; pe_b = pe_cnt; ov_b = ov_cnt; busy_b = busy_cnt; e2_b = e2_cnt;
  endtask

  // Start bit, 8 data bits LSB first, even parity bit, one stop bit.
  function automatic logic [15:0] frame8(input logic [7:0] d, input bit par_bad, input bit stop);
    logic [15:0] f = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    f[9]   = 1'($countones(d) % 2) ^ par_bad;
    f[10]  = stop;
    return f;
  endfunction

  function automatic logic [15:0] frame7(input logic [6:0] d);
    logic [15:0] f = '1;
    f[0]   = 1'b0;
    f[7:1] = d;
    return f;
  endfunction

  // Drives one frame, one bit per CLKS cycles; optionally pulses rx_ready on cycle
  // ready_at, stops early after stop_at cycles, or leaves the line low afterwards.
  task automatic send(input int which, input logic [15:0] bits, input int nbits,
                      input int ready_at, input bit hold_low, input int stop_at);
    int total = nbits * CLKS;
    if (stop_at > 0 && stop_at < total) total = stop_at;
    for (int c = 0; c < total; c++) begin
      @(posedge clk); #1;
      if (c == 0) fall_cyc = cyc;
      if (which == 0) serial_in = bits[c / CLKS];
      else            serial_in2 = bits[c / CLKS];
      if (ready_at >= 0) rx_ready = (c == ready_at);
    end
    @(posedge clk); #1;
    if (!hold_low) begin
      serial_in  = 1'b1;
      serial_in2 = 1'b1;
    end
    if (ready_at >= 0) rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Frame-level model update; returns the overrun pulse count the frame should cause.
  function automatic int model_frame(input logic [7:0] d, input bit good, input bit ready_load);
    int ov = 0;
    if (good) begin
      if (!m_valid || ready_load) begin
        m_valid = 1'b1;
        m_data  = d;
      end else begin
        ov = 1;
      end
    end
    return ov;
  endfunction

  task automatic frame_check(input string tag, input int exp_fe, input int exp_pe, input int exp_ov);
    @(negedge clk);
    check({tag, ".ferr"},  32'(fe_cnt - fe_b), 32'(exp_fe));
    check({tag, ".perr"},  32'(pe_cnt - pe_b), 32'(exp_pe));
    check({tag, ".ovr"},   32'(ov_cnt - ov_b), 32'(exp_ov));
    check({tag, ".valid"}, 32'(rx.rx_valid), 32'(m_valid));
    check({tag, ".data"},  32'(rx.rx_data), 32'(m_data));
    check({tag, ".busy"},  32'(rx.busy), 32'd0);
  endtask

  task automatic consume();
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    m_valid = 1'b0;
  endtask

  initial begin
    int ov;
    n_rst = 1'b0; serial_in = 1'b1; serial_in2 = 1'b1; rx_ready = 1'b0;
    m_valid = 1'b0; m_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.outs", {rx.rx_valid, rx.framing_error, rx.parity_error, rx.overrun_error, rx.busy}, 32'd0);
    check("reset.data", 32'(rx.rx_data), 32'd0);
    @(posedge clk); #1 n_rst = 1'b1;
    repeat (4) @(posedge clk); #1;

    // Clean frame, consumer not ready: word buffered with the documented latency.
    snap();
    send(0, frame8(8'hA5, 1'b0, 1'b1), 11, -1, 1'b0, 0);
    ov = model_frame(8'hA5, 1'b1, 1'b0);
    frame_check("t1", 0, 0, ov);
    check("t1.latency", 32'(rise_cyc - fall_cyc), 32'(LAT8));
    consume();
    @(negedge clk);
    check("t1.consumed", 32'(rx.rx_valid), 32'd0);

    // Short low glitch: START rejects it after half a bit.
    snap();
    @(posedge clk); #1 serial_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 serial_in = 1'b1;
    repeat (20) @(posedge clk);
    frame_check("t2", 0, 0, 0);
    check("t2.busy_cycles", 32'(busy_cnt - busy_b), 32'(CLKS / 2 + 1));

    // Bad parity bit.
    snap();
    send(0, frame8(8'h3C, 1'b1, 1'b1), 11, -1, 1'b0, 0);
    frame_check("t3", 0, 1, 0);

    // Stop bit low, then a 40-cycle break: no restart while the line stays low.
    snap();
    send(0, frame8(8'h81, 1'b0, 1'b0), 11, -1, 1'b1, 0);
    busy_b = busy_cnt;
    repeat (40) @(posedge clk);
    #1 serial_in = 1'b1;
    repeat (4) @(posedge clk);
    frame_check("t4", 1, 0, 0);
    check("t4.break_busy", 32'(busy_cnt - busy_b), 32'd0);

    // Overrun keeps the old word; a ready in the LOAD cycle lets the new one in.
    snap();
    send(0, frame8(8'h11, 1'b0, 1'b1), 11, -1, 1'b0, 0);
    ov = model_frame(8'h11, 1'b1, 1'b0);
    frame_check("t5a", 0, 0, ov);
    snap();
    send(0, frame8(8'h22, 1'b0, 1'b1), 11, -1, 1'b0, 0);
    ov = model_frame(8'h22, 1'b1, 1'b0);
    frame_check("t5b", 0, 0, ov);
    snap();
    send(0, frame8(8'h22, 1'b0, 1'b1), 11, LAT8 - 1, 1'b0, 0);
    ov = model_frame(8'h22, 1'b1, 1'b1);
    frame_check("t5c", 0, 0, ov);

    // Reset in the middle of data bit 4 discards the frame and the buffered word.
    send(0, frame8(8'h5A, 1'b0, 1'b1), 11, -1, 1'b0, 5 * CLKS + 8);
    n_rst = 1'b0;
    #2;
    check("t6.rst_outs", {rx.rx_valid, rx.framing_error, rx.parity_error, rx.overrun_error, rx.busy}, 32'd0);
    check("t6.rst_data", 32'(rx.rx_data), 32'd0);
    m_valid = 1'b0; m_data = 8'h00;
    @(posedge clk); #1 n_rst = 1'b1;
    repeat (5) @(posedge clk); #1;
    snap();
    send(0, frame8(8'h5A, 1'b0, 1'b1), 11, -1, 1'b0, 0);
    ov = model_frame(8'h5A, 1'b1, 1'b0);
    frame_check("t6", 0, 0, ov);
    consume();

    // 7 data bits, no parity, two stop bits.
    snap();
    send(1, frame7(7'h25), 10, -1, 1'b0, 0);
    @(negedge clk);
    check("t7.valid", 32'(rx2.rx_valid), 32'd1);
    check("t7.data", 32'(rx2.rx_data), 32'h25);
    check("t7.errs", 32'(e2_cnt - e2_b), 32'd0);

    // Randomized frames with occasional parity/stop faults and random consumption.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      bit par_bad, stop_bad;
      d        = 8'($urandom);
      par_bad  = ($urandom_range(0, 3) == 0);
      stop_bad = ($urandom_range(0, 3) == 0);
      snap();
      send(0, frame8(d, par_bad, !stop_bad), 11, -1, 1'b0, 0);
      ov = model_frame(d, !par_bad && !stop_bad, 1'b0);
      frame_check($sformatf("rnd%0d", i), int'(stop_bad), int'(par_bad), ov);
      if ($urandom_range(0, 1) == 1) consume();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
